cordic_issue_sched: RTL

Two-port issue scheduler and result buffer for the fixed-latency, non-stallable CORDIC pipeline chain. It accepts rotation jobs (x, y, z) from two requesters over valid/ready and arbitrates round-robin. It issues at most one job per cycle into the chain and tracks each job's source through a tag delay line matched to the chain latency. Results land in an output FIFO with backpressure, and credit-based issue guarantees no result is ever dropped.

---
 rtl/cordic_issue_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cordic_issue_sched.sv
// Two-requester round-robin issue scheduler for a fixed-latency CORDIC chain,
// with a source-tag delay line and a credit-protected first-word-fall-through result FIFO.
module cordic_issue_sched #(
    parameter int NXY   = 32,
    parameter int NZ    = 32,
    parameter int LAT   = 8,
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [NXY-1:0] a_x,
    input  logic [NXY-1:0] a_y,
    input  logic [NZ-1:0]  a_z,
    input  logic           b_valid,
    output logic           b_ready,
    input  logic [NXY-1:0] b_x,
    input  logic [NXY-1:0] b_y,
    input  logic [NZ-1:0]  b_z,
    output logic [NXY-1:0] pipe_xi,
    output logic [NXY-1:0] pipe_yi,
    output logic [NZ-1:0]  pipe_zi,
    input  logic [NXY-1:0] pipe_xo,
    input  logic [NXY-1:0] pipe_yo,
    input  logic [NZ-1:0]  pipe_zo,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [NXY-1:0] res_x,
    output logic [NXY-1:0] res_y,
    output logic [NZ-1:0]  res_zo,
    output logic           res_src,
    output logic           busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    function automatic logic [AW-1:0] f_ptr_inc(input logic [AW-1:0] p);
        f_ptr_inc = (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    logic           r_iv;
    logic           r_isrc;
    logic [NXY-1:0] r_ix;
    logic [NXY-1:0] r_iy;
    logic [NZ-1:0]  r_iz;
    logic           r_rr;
    logic [CW-1:0]  r_cnt;
    logic           r_dl_v   [LAT];
    logic           r_dl_src [LAT];
    logic [NXY-1:0] r_mem_x  [DEPTH];
    logic [NXY-1:0] r_mem_y  [DEPTH];
    logic [NZ-1:0]  r_mem_z  [DEPTH];
    logic           r_mem_s  [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_occ;

    logic w_credit;
    logic w_grant_a;
    logic w_grant_b;
    logic w_acc_a;
    logic w_acc_b;
    logic w_acc;
    logic w_wr;
    logic w_pop;

    // r_cnt tracks issue-reg + delay-line + FIFO population: each job enters on accept and leaves on pop.
    assign w_credit  = (r_cnt < CW'(DEPTH));
    assign w_grant_a = a_valid & (~b_valid | ~r_rr);
    assign w_grant_b = b_valid & (~a_valid | r_rr);
    assign a_ready   = ~reset & w_credit & w_grant_a;
    assign b_ready   = ~reset & w_credit & w_grant_b;
    assign w_acc_a   = a_valid & a_ready;
    assign w_acc_b   = b_valid & b_ready;
    assign w_acc     = w_acc_a | w_acc_b;
    assign w_wr      = r_dl_v[LAT-1];
    assign w_pop     = res_valid & res_ready;

    assign pipe_xi   = r_ix;
    assign pipe_yi   = r_iy;
    assign pipe_zi   = r_iz;
    assign res_valid = (r_occ != {CW{1'b0}});
    assign busy      = (r_cnt != {CW{1'b0}});
    // Stale storage is masked so an empty FIFO presents zeros.
    assign res_x     = res_valid ? r_mem_x[r_rptr] : {NXY{1'b0}};
    assign res_y     = res_valid ? r_mem_y[r_rptr] : {NXY{1'b0}};
    assign res_zo    = res_valid ? r_mem_z[r_rptr] : {NZ{1'b0}};
    assign res_src   = res_valid ? r_mem_s[r_rptr] : 1'b0;

    // Control state: issue register, arbitration pointer, tag delay line, FIFO pointers and credits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iv   <= 1'b0;
            r_isrc <= 1'b0;
            r_ix   <= {NXY{1'b0}};
            r_iy   <= {NXY{1'b0}};
            r_iz   <= {NZ{1'b0}};
            r_rr   <= 1'b0;
            r_cnt  <= {CW{1'b0}};
            r_wptr <= {AW{1'b0}};
            r_rptr <= {AW{1'b0}};
            r_occ  <= {CW{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                r_dl_v[i]   <= 1'b0;
                r_dl_src[i] <= 1'b0;
            end
        end else begin
            r_iv <= w_acc;
            if (w_acc) begin
                r_isrc <= w_acc_b;
                r_ix   <= w_acc_b ? b_x : a_x;
                r_iy   <= w_acc_b ? b_y : a_y;
                r_iz   <= w_acc_b ? b_z : a_z;
                r_rr   <= w_acc_a;
            end
            r_dl_v[0]   <= r_iv;
            r_dl_src[0] <= r_isrc;
            for (int i = 1; i < LAT; i++) begin
                r_dl_v[i]   <= r_dl_v[i-1];
                r_dl_src[i] <= r_dl_src[i-1];
            end
            if (w_wr) begin
                r_wptr <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            case ({w_wr, w_pop})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
            case ({w_acc, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Result storage is written only; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_wr && !reset) begin
            r_mem_x[r_wptr] <= pipe_xo;
            r_mem_y[r_wptr] <= pipe_yo;
            r_mem_z[r_wptr] <= pipe_zo;
            r_mem_s[r_wptr] <= r_dl_src[LAT-1];
        end
    end
endmodule
